// File: rtl/usb_defs.sv
// rtl/usb_defs.sv - USB PID constants and bulk-OUT transaction FSM encoding
package usb_defs;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_DISCARD = 2'd2,
    S_HSK     = 2'd3
  } xfer_state_e;

  // Data PID the host must send next for a given expected-toggle bit.
  function automatic logic [3:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/bulk_out_pkt_buf.sv
// rtl/bulk_out_pkt_buf.sv - single-packet byte buffer, sync write, 1-cycle sync read
module bulk_out_pkt_buf #(
  parameter int ABITS = 9
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [ABITS-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic             rd_en_i,
  input  logic [ABITS-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [2**ABITS];
  logic [7:0] rd_data_q;

  // Write port: one received payload byte per cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read port: output holds its value when no read is issued, so a stalled
  // drain pipeline keeps its byte without re-reading.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bulk_out_xfer_ctrl.sv
// rtl/bulk_out_xfer_ctrl.sv - USB bulk-OUT transaction engine; PING support under BULK_OUT_PING_EN
module bulk_out_xfer_ctrl
  import usb_defs::*;
#(
  parameter int MAX_PACKET = 512,
  parameter int ABITS      = 9,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic       bulk_ep_out_clock,
  input  logic       reset_n,
  input  logic       token_out_i,
  input  logic       ping_i,
  input  logic       rx_tvalid_i,
  input  logic       rx_tlast_i,
  input  logic [7:0] rx_tdata_i,
  input  logic [3:0] rx_pid_i,
  input  logic       rx_crc_ok_i,
  input  logic       rx_err_i,
  output logic       hsk_send_o,
  output logic [3:0] hsk_pid_o,
  input  logic       hsk_done_i,
  input  logic       stall_i,
  input  logic       clear_toggle_i,
  input  logic       bulk_ep_out_ready_read_i,
  output logic       bulk_ep_out_xfer_o,
  output logic       bulk_ep_out_tvalid_o,
  output logic       bulk_ep_out_tlast_o,
  output logic [7:0] bulk_ep_out_tdata_o,
  input  logic       bulk_ep_out_tready_i
);

  localparam int CW = ABITS + 1;
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam logic [CW-1:0] MAXP     = CW'(MAX_PACKET);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RX_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  xfer_state_e   state_q;
  logic          toggle_q, buf_busy_q, ovf_q, seen_q, hsk_send_q, xfer_q;
  logic [3:0]    pid_q, hsk_pid_q;
  logic [CW-1:0] cnt_q, len_q;
  logic [TW-1:0] timer_q;

  logic          rptr_unused_ok;
  logic [CW-1:0] rptr_q, ld_cnt_q;
  logic          s1_vld_q, tvalid_q, tlast_q, out_last_q;
  logic [7:0]    tdata_q, rd_data;

  // Receive-side helpers: values as they will be once this cycle's byte lands.
  logic          rx_active, cnt_room, ovf_now, pkt_good, wr_en;
  logic [CW-1:0] cnt_now;
  logic [3:0]    pid_now;

  assign rx_active = rx_tvalid_i || rx_tlast_i;
  assign cnt_room  = cnt_q < MAXP;
  assign cnt_now   = (rx_tvalid_i && cnt_room) ? cnt_q + CNT_ONE : cnt_q;
  assign ovf_now   = ovf_q || (rx_tvalid_i && !cnt_room);
  assign pid_now   = seen_q ? pid_q : rx_pid_i;
  assign pkt_good  = rx_crc_ok_i && !rx_err_i;
  assign wr_en     = (state_q == S_RECV) && rx_tvalid_i && cnt_room;

  // Drain pipeline control: RAM read stage feeding the AXIS output register.
  logic load_out, rd_en, drain_done;

  assign load_out   = s1_vld_q && (!tvalid_q || bulk_ep_out_tready_i);
  assign rd_en      = buf_busy_q && (rptr_q < len_q) && (!s1_vld_q || load_out);
  assign drain_done = buf_busy_q &&
                      ((len_q == '0) || (tvalid_q && bulk_ep_out_tready_i && out_last_q));
  assign rptr_unused_ok = 1'b1;

  bulk_out_pkt_buf #(.ABITS(ABITS)) u_buf (
    .clk_i     (bulk_ep_out_clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q[ABITS-1:0]),
    .wr_data_i (rx_tdata_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rptr_q[ABITS-1:0]),
    .rd_data_o (rd_data)
  );

  // Transaction FSM: token/packet reception, handshakes, data toggle and buffer ownership.
  always_ff @(posedge bulk_ep_out_clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      toggle_q   <= 1'b0;
      buf_busy_q <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      seen_q     <= 1'b0;
      pid_q      <= '0;
      timer_q    <= '0;
      hsk_send_q <= 1'b0;
      hsk_pid_q  <= '0;
      xfer_q     <= 1'b0;
    end else begin
      xfer_q <= 1'b0;
      if (drain_done) begin
        buf_busy_q <= 1'b0;
        xfer_q     <= (len_q < MAXP);
      end
      case (state_q)
        S_IDLE: begin
          if (token_out_i) begin
            state_q <= (!stall_i && !buf_busy_q && bulk_ep_out_ready_read_i) ? S_RECV : S_DISCARD;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            seen_q  <= 1'b0;
            timer_q <= '0;
          end
`ifdef BULK_OUT_PING_EN
          else if (ping_i) begin
            state_q    <= S_HSK;
            hsk_send_q <= 1'b1;
            if (stall_i)
              hsk_pid_q <= PID_STALL;
            else if (!buf_busy_q && bulk_ep_out_ready_read_i)
              hsk_pid_q <= PID_ACK;
            else
              hsk_pid_q <= PID_NAK;
          end
`endif
        end
        S_RECV, S_DISCARD: begin
          if (rx_active)
            timer_q <= '0;
          else if (timer_q == TMO_LAST)
            state_q <= S_IDLE;
          else
            timer_q <= timer_q + TMO_ONE;
          if (rx_active && !seen_q) begin
            seen_q <= 1'b1;
            pid_q  <= rx_pid_i;
          end
          if (state_q == S_RECV) begin
            cnt_q <= cnt_now;
            if (rx_tvalid_i && !cnt_room) ovf_q <= 1'b1;
          end
          if (rx_tlast_i) begin
            state_q <= S_IDLE;
            if (state_q == S_RECV) begin
              if (pkt_good && !ovf_now) begin
                state_q    <= S_HSK;
                hsk_send_q <= 1'b1;
                hsk_pid_q  <= PID_ACK;
                // A duplicate (wrong toggle) is acknowledged but its data dropped.
                if (pid_now == data_pid(toggle_q)) begin
                  toggle_q   <= ~toggle_q;
                  buf_busy_q <= 1'b1;
                  len_q      <= cnt_now;
                end
              end
            end else if (pkt_good) begin
              state_q    <= S_HSK;
              hsk_send_q <= 1'b1;
              hsk_pid_q  <= stall_i ? PID_STALL : PID_NAK;
            end
          end
        end
        S_HSK: begin
          if (hsk_done_i) begin
            hsk_send_q <= 1'b0;
            hsk_pid_q  <= '0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (clear_toggle_i) toggle_q <= 1'b0;
    end
  end

  // Drain: replay the stored packet as AXIS beats, restarting from address 0 each packet.
  always_ff @(posedge bulk_ep_out_clock) begin
    if (!reset_n || drain_done) begin
      rptr_q     <= '0;
      ld_cnt_q   <= '0;
      s1_vld_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      out_last_q <= 1'b0;
      tdata_q    <= '0;
    end else begin
      if (rd_en) rptr_q <= rptr_q + CNT_ONE;
      if (rd_en)
        s1_vld_q <= 1'b1;
      else if (load_out)
        s1_vld_q <= 1'b0;
      if (load_out) begin
        tvalid_q   <= 1'b1;
        tdata_q    <= rd_data;
        out_last_q <= (ld_cnt_q == len_q - CNT_ONE);
        tlast_q    <= (ld_cnt_q == len_q - CNT_ONE) && (len_q < MAXP);
        ld_cnt_q   <= ld_cnt_q + CNT_ONE;
      end else if (tvalid_q && bulk_ep_out_tready_i) begin
        tvalid_q   <= 1'b0;
        tlast_q    <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

`ifndef BULK_OUT_PING_EN
  logic unused_ping;
  assign unused_ping = ping_i & rptr_unused_ok;
`endif

  assign hsk_send_o           = hsk_send_q;
  assign hsk_pid_o            = hsk_pid_q;
  assign bulk_ep_out_xfer_o   = xfer_q;
  assign bulk_ep_out_tvalid_o = tvalid_q;
  assign bulk_ep_out_tlast_o  = tlast_q;
  assign bulk_ep_out_tdata_o  = tdata_q;

endmodule

// File: tb/tb_bulk_out_xfer_ctrl.sv
// tb/tb_bulk_out_xfer_ctrl.sv - directed self-checking bench for bulk_out_xfer_ctrl
`timescale 1ns/1ps
module tb_bulk_out_xfer_ctrl;

  localparam logic [3:0] D0 = 4'h3, D1 = 4'hB, ACK = 4'h2, NAK = 4'hA, STALL = 4'hE;

  logic bulk_ep_out_clock = 1'b0;
  logic reset_n = 1'b0;
  logic token_out_i = 0, ping_i = 0, rx_tvalid_i = 0, rx_tlast_i = 0;
  logic [7:0] rx_tdata_i = 0;
  logic [3:0] rx_pid_i = 0;
  logic rx_crc_ok_i = 0, rx_err_i = 0, hsk_done_i = 0, stall_i = 0, clear_toggle_i = 0;
  logic ready_read = 1'b1, tready = 1'b1;
  logic hsk_send_o, xfer_o, tvalid_o, tlast_o;
  logic [3:0] hsk_pid_o;
  logic [7:0] tdata_o;

  int total = 0, bad = 0;
  logic [8:0] beats[$];
  int xfer_cnt = 0;
  logic rand_rdy = 1'b0, tready_fix = 1'b1;

  always #5 bulk_ep_out_clock = ~bulk_ep_out_clock;

  bulk_out_xfer_ctrl dut (
    .bulk_ep_out_clock        (bulk_ep_out_clock),
    .reset_n                  (reset_n),
    .token_out_i              (token_out_i),
    .ping_i                   (ping_i),
    .rx_tvalid_i              (rx_tvalid_i),
    .rx_tlast_i               (rx_tlast_i),
    .rx_tdata_i               (rx_tdata_i),
    .rx_pid_i                 (rx_pid_i),
    .rx_crc_ok_i              (rx_crc_ok_i),
    .rx_err_i                 (rx_err_i),
    .hsk_send_o               (hsk_send_o),
    .hsk_pid_o                (hsk_pid_o),
    .hsk_done_i               (hsk_done_i),
    .stall_i                  (stall_i),
    .clear_toggle_i           (clear_toggle_i),
    .bulk_ep_out_ready_read_i (ready_read),
    .bulk_ep_out_xfer_o       (xfer_o),
    .bulk_ep_out_tvalid_o     (tvalid_o),
    .bulk_ep_out_tlast_o      (tlast_o),
    .bulk_ep_out_tdata_o      (tdata_o),
    .bulk_ep_out_tready_i     (tready)
  );

  always @(negedge bulk_ep_out_clock) begin
    if (rand_rdy) tready = 1'($urandom_range(0, 1));
    else tready = tready_fix;
  end

  always @(negedge bulk_ep_out_clock) begin
    #1;
    if (reset_n) begin
      if (tvalid_o && tready) beats.push_back({tlast_o, tdata_o});
      if (xfer_o) xfer_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge bulk_ep_out_clock);
  endtask

  task automatic send_pkt(input logic [3:0] pid, input int n, input logic [7:0] base,
                          input logic crc, input logic err);
    token_out_i = 1'b1; tick(); token_out_i = 1'b0; tick();
    rx_pid_i = pid; rx_crc_ok_i = crc; rx_err_i = err;
    if (n == 0) begin
      rx_tlast_i = 1'b1; tick();
    end else begin
      for (int i = 0; i < n; i++) begin
        rx_tvalid_i = 1'b1;
        rx_tdata_i  = base + 8'(i);
        rx_tlast_i  = (i == n - 1);
        tick();
      end
    end
    rx_tvalid_i = 0; rx_tlast_i = 0; rx_crc_ok_i = 0; rx_err_i = 0; rx_tdata_i = 0;
  endtask

  task automatic do_hsk(output logic got, output logic [3:0] pid);
    got = 1'b0; pid = 4'h0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (hsk_send_o) begin got = 1'b1; pid = hsk_pid_o; end
      else tick();
    end
    if (got) begin hsk_done_i = 1'b1; tick(); hsk_done_i = 1'b0; tick(); end
  endtask

  task automatic wait_beats(input int n, input int max);
    for (int i = 0; i < max && beats.size() < n; i++) tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; repeat (3) tick();
    total++; if ({hsk_send_o, hsk_pid_o, xfer_o, tvalid_o, tlast_o, tdata_o} !== 16'h0) begin
      bad++; $display("FAIL reset_outputs got=%0h want=0", {hsk_send_o, hsk_pid_o, xfer_o, tvalid_o, tlast_o, tdata_o}); end
    reset_n = 1'b1; tick();
    total++; if ({hsk_send_o, xfer_o, tvalid_o} !== 3'b0) begin
      bad++; $display("FAIL reset_release got=%0b want=0", {hsk_send_o, xfer_o, tvalid_o}); end
  endtask

  task automatic test_short_ack;
    logic got; logic [3:0] pid; logic [8:0] exp;
    beats.delete(); xfer_cnt = 0;
    send_pkt(D0, 10, 8'h00, 1'b1, 1'b0);
    total++; if (hsk_send_o !== 1'b1 || hsk_pid_o !== ACK) begin
      bad++; $display("FAIL short_hsk got=%0b/%0h want=1/2", hsk_send_o, hsk_pid_o); end
    total++; if (tvalid_o !== 1'b0) begin bad++; $display("FAIL short_lat1 got=%0b want=0", tvalid_o); end
    tick();
    total++; if (tvalid_o !== 1'b0) begin bad++; $display("FAIL short_lat2 got=%0b want=0", tvalid_o); end
    tick();
    total++; if (tvalid_o !== 1'b1 || tdata_o !== 8'h00) begin
      bad++; $display("FAIL short_first got=%0b/%0h want=1/0", tvalid_o, tdata_o); end
    do_hsk(got, pid);
    total++; if (hsk_send_o !== 1'b0) begin bad++; $display("FAIL short_hsk_drop got=%0b want=0", hsk_send_o); end
    repeat (20) tick();
    total++; if (beats.size() != 10) begin bad++; $display("FAIL short_count got=%0d want=10", beats.size()); end
    else for (int i = 0; i < 10; i++) begin
      exp = {(i == 9), 8'(i)};
      total++; if (beats[i] !== exp) begin bad++; $display("FAIL short_beat%0d got=%0h want=%0h", i, beats[i], exp); end
    end
    total++; if (xfer_cnt != 1) begin bad++; $display("FAIL short_xfer got=%0d want=1", xfer_cnt); end
  endtask

  task automatic test_duplicate;
    logic got; logic [3:0] pid;
    beats.delete(); xfer_cnt = 0;
    send_pkt(D0, 10, 8'h20, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== ACK) begin bad++; $display("FAIL dup_hsk got=%0b/%0h want=1/2", got, pid); end
    repeat (20) tick();
    total++; if (beats.size() != 0 || xfer_cnt != 0) begin
      bad++; $display("FAIL dup_beats got=%0d/%0d want=0/0", beats.size(), xfer_cnt); end
  endtask

  task automatic test_nak_stall;
    logic got; logic [3:0] pid;
    beats.delete();
    ready_read = 1'b0;
    send_pkt(D1, 4, 8'h30, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== NAK) begin bad++; $display("FAIL nak_hsk got=%0b/%0h want=1/a", got, pid); end
    ready_read = 1'b1; stall_i = 1'b1;
    send_pkt(D1, 4, 8'h30, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== STALL) begin bad++; $display("FAIL stall_hsk got=%0b/%0h want=1/e", got, pid); end
    stall_i = 1'b0;
    repeat (10) tick();
    total++; if (beats.size() != 0) begin bad++; $display("FAIL nak_beats got=%0d want=0", beats.size()); end
  endtask

  task automatic test_bad_packet;
    logic got; logic [3:0] pid; logic [8:0] exp;
    beats.delete(); xfer_cnt = 0;
    send_pkt(D1, 4, 8'h50, 1'b0, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b0) begin bad++; $display("FAIL badcrc_hsk got=%0b want=0", got); end
    send_pkt(D1, 4, 8'h50, 1'b1, 1'b1);
    do_hsk(got, pid);
    total++; if (got !== 1'b0) begin bad++; $display("FAIL err_hsk got=%0b want=0", got); end
    send_pkt(D1, 3, 8'h40, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== ACK) begin bad++; $display("FAIL after_bad_hsk got=%0b/%0h want=1/2", got, pid); end
    repeat (10) tick();
    total++; if (beats.size() != 3) begin bad++; $display("FAIL after_bad_count got=%0d want=3", beats.size()); end
    else for (int i = 0; i < 3; i++) begin
      exp = {(i == 2), 8'h40 + 8'(i)};
      total++; if (beats[i] !== exp) begin bad++; $display("FAIL after_bad_beat%0d got=%0h want=%0h", i, beats[i], exp); end
    end
    total++; if (xfer_cnt != 1) begin bad++; $display("FAIL after_bad_xfer got=%0d want=1", xfer_cnt); end
  endtask

  task automatic test_overflow;
    logic got; logic [3:0] pid;
    beats.delete();
    send_pkt(D0, 513, 8'h00, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b0 || beats.size() != 0) begin
      bad++; $display("FAIL ovf got=%0b/%0d want=0/0", got, beats.size()); end
  endtask

  task automatic test_full_drain;
    logic got; logic [3:0] pid; logic [8:0] exp; int errs;
    beats.delete(); xfer_cnt = 0; rand_rdy = 1'b1;
    send_pkt(D0, 512, 8'h00, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== ACK) begin bad++; $display("FAIL full_hsk got=%0b/%0h want=1/2", got, pid); end
    send_pkt(D1, 4, 8'h60, 1'b1, 1'b0);
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== NAK) begin bad++; $display("FAIL busy_nak got=%0b/%0h want=1/a", got, pid); end
    wait_beats(512, 5000);
    rand_rdy = 1'b0; tready_fix = 1'b1;
    repeat (10) tick();
    total++; if (beats.size() != 512) begin bad++; $display("FAIL full_count got=%0d want=512", beats.size()); end
    else begin
      errs = 0;
      for (int i = 0; i < 512; i++) begin
        exp = {1'b0, 8'(i)};
        if (beats[i] !== exp && errs < 4) begin
          errs++; $display("FAIL full_beat%0d got=%0h want=%0h", i, beats[i], exp);
        end else if (beats[i] !== exp) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL full_data got=%0d_errors want=0", errs); end
    end
    total++; if (xfer_cnt != 0 || tvalid_o !== 1'b0) begin
      bad++; $display("FAIL full_end got=%0d/%0b want=0/0", xfer_cnt, tvalid_o); end
  endtask

  task automatic test_clear_toggle_zlp;
    logic got; logic [3:0] pid;
    beats.delete(); xfer_cnt = 0;
    clear_toggle_i = 1'b1; tick(); clear_toggle_i = 1'b0;
    send_pkt(D1, 5, 8'h70, 1'b1, 1'b0);
    do_hsk(got, pid);
    repeat (10) tick();
    total++; if (got !== 1'b1 || pid !== ACK || beats.size() != 0) begin
      bad++; $display("FAIL clear_dup got=%0b/%0h/%0d want=1/2/0", got, pid, beats.size()); end
    send_pkt(D0, 0, 8'h00, 1'b1, 1'b0);
    total++; if (hsk_send_o !== 1'b1 || hsk_pid_o !== ACK || xfer_o !== 1'b0) begin
      bad++; $display("FAIL zlp_ack got=%0b/%0h/%0b want=1/2/0", hsk_send_o, hsk_pid_o, xfer_o); end
    tick();
    total++; if (xfer_o !== 1'b1) begin bad++; $display("FAIL zlp_xfer got=%0b want=1", xfer_o); end
    do_hsk(got, pid);
    repeat (5) tick();
    total++; if (beats.size() != 0 || xfer_cnt != 1) begin
      bad++; $display("FAIL zlp_end got=%0d/%0d want=0/1", beats.size(), xfer_cnt); end
  endtask

  task automatic test_reset_mid_drain;
    logic got; logic [3:0] pid;
    beats.delete(); xfer_cnt = 0; tready_fix = 1'b0;
    send_pkt(D1, 20, 8'h90, 1'b1, 1'b0);
    do_hsk(got, pid);
    repeat (4) tick();
    total++; if (tvalid_o !== 1'b1 || tdata_o !== 8'h90) begin
      bad++; $display("FAIL mid_hold got=%0b/%0h want=1/90", tvalid_o, tdata_o); end
    reset_n = 1'b0; tick();
    total++; if (tvalid_o !== 1'b0 || hsk_send_o !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%0b/%0b want=0/0", tvalid_o, hsk_send_o); end
    reset_n = 1'b1; tready_fix = 1'b1;
    repeat (30) tick();
    total++; if (beats.size() != 0 || xfer_cnt != 0) begin
      bad++; $display("FAIL mid_after got=%0d/%0d want=0/0", beats.size(), xfer_cnt); end
  endtask

  task automatic test_ping;
    logic got; logic [3:0] pid;
    beats.delete(); xfer_cnt = 0;
    ping_i = 1'b1; tick(); ping_i = 1'b0;
    do_hsk(got, pid);
`ifdef BULK_OUT_PING_EN
    total++; if (got !== 1'b1 || pid !== ACK) begin bad++; $display("FAIL ping_ack got=%0b/%0h want=1/2", got, pid); end
    tready_fix = 1'b0;
    send_pkt(D0, 5, 8'hA0, 1'b1, 1'b0);
    do_hsk(got, pid);
    ping_i = 1'b1; tick(); ping_i = 1'b0;
    do_hsk(got, pid);
    total++; if (got !== 1'b1 || pid !== NAK) begin bad++; $display("FAIL ping_busy got=%0b/%0h want=1/a", got, pid); end
    tready_fix = 1'b1;
    wait_beats(5, 100);
    repeat (5) tick();
    total++; if (beats.size() != 5 || xfer_cnt != 1) begin
      bad++; $display("FAIL ping_drain got=%0d/%0d want=5/1", beats.size(), xfer_cnt); end
`else
    total++; if (got !== 1'b0) begin bad++; $display("FAIL ping_ignored got=%0b want=0", got); end
`endif
  endtask

  initial begin
    test_reset();
    test_short_ack();
    test_duplicate();
    test_nak_stall();
    test_bad_packet();
    test_overflow();
    test_full_drain();
    test_clear_toggle_zlp();
    test_reset_mid_drain();
    test_ping();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
